// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronizes the raw pins, deframes and validates 11-bit frames,
// buffers good bytes and presents them as one-cycle strobes spaced at least GAP cycles apart.
module ps2_receiver #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out,
  output logic       frame_error,
  output logic       fifo_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic clk_s1, clk_s2, clk_s3, dat_s1, dat_s2;
  logic fall;

  state_t state, state_nxt;
  logic [3:0]    bitcnt;
  logic [10:0]   shreg;
  logic [TW-1:0] idle_cnt;
  logic          timeout_err;
  logic          frame_valid;
  logic          in_check;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic [GW-1:0] gap;

  // Bus idles high, so the sync chain resets to 1 to avoid a phantom fall edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clock;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    timeout_err = 1'b0;
    case (state)
      IDLE:  if (fall && !dat_s2) state_nxt = RECV;
      RECV: begin
        if (fall) begin
          if (bitcnt == 4'd10) state_nxt = CHECK;
        end else if (idle_cnt == TW'(TIMEOUT)) begin
          state_nxt   = IDLE;
          timeout_err = 1'b1;
        end
      end
      CHECK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame shifts in from the top, so after 11 bits start sits at [0] and stop at [10].
  always_ff @(posedge clock) begin
    if (reset) begin
      bitcnt   <= '0;
      shreg    <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (fall && !dat_s2) begin
            shreg  <= {1'b0, shreg[10:1]};
            bitcnt <= 4'd1;
          end
        end
        RECV: begin
          if (fall) begin
            shreg    <= {dat_s2, shreg[10:1]};
            bitcnt   <= bitcnt + 4'd1;
            idle_cnt <= '0;
          end else if (timeout_err) begin
            bitcnt   <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        default: bitcnt <= '0;
      endcase
    end
  end

  assign in_check      = (state == CHECK);
  assign frame_valid   = ~shreg[0] & shreg[10] & (^shreg[9:1]);
  assign full          = (count == CW'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign pop           = !empty && (gap == '0);
  assign push          = in_check && frame_valid && (!full || pop);
  assign fifo_overflow = in_check && frame_valid && full && !pop;
  assign frame_error   = (in_check && !frame_valid) || timeout_err;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= shreg[8:1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Presenter: the gap counter enforces strobe spacing for the pipeline's sampling.
  always_ff @(posedge clock) begin
    if (reset) begin
      gap             <= '0;
      ps2_out         <= 8'h00;
      ps2_key_pressed <= 1'b0;
    end else begin
      ps2_key_pressed <= pop;
      if (pop) begin
        ps2_out <= mem[rd_ptr];
        gap     <= GW'(GAP - 1);
      end else if (gap != '0) begin
        gap <= gap - GW'(1);
      end
    end
  end

endmodule
